// File: rtl/axi4_lite_addr_decoder.sv
// axi4_lite_addr_decoder: per-master AXI4-Lite address decoder for the interconnect.
// Decodes AW/AR addresses against SLAVE_NUM base/mask windows, flags unmapped addresses
// (DECERR), and tracks in-flight transactions per direction. A new address to a different
// target is stalled while responses are pending, so responses come back in order.
// Optional macro AXI_ADDR_DEC_ERR_LOG_EN adds a sticky log of the last DECERR address handshake.

// One direction (AW/B or AR/R): outstanding counter, current target and response routing.
module axi4_lite_addr_decoder_chan #(
  parameter int SLAVE_NUM       = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TW              = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TW-1:0]        tgt_i,
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic                 rsp_valid_i,
  input  logic                 rsp_ready_i,
  output logic                 stall_o,
  output logic [SLAVE_NUM-1:0] rsp_sel_o,
  output logic                 rsp_decerr_o
);
  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  // The error responder is encoded as one past the last slave index.
  localparam logic [TW-1:0] ERR_TGT = TW'(SLAVE_NUM);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] cur_tgt_q, cur_tgt_d;
  logic          cnt_nz, addr_hs, rsp_hs;

  assign cnt_nz  = (cnt_q != '0);
  assign stall_o = valid_i & ((cnt_q == MAX_CNT) | (cnt_nz & (tgt_i != cur_tgt_q)));
  assign addr_hs = valid_i & ready_i & ~stall_o;
  // A response with nothing outstanding is ignored so the counter cannot underflow.
  assign rsp_hs  = rsp_valid_i & rsp_ready_i & cnt_nz;

  // Next-state for the outstanding count and the target responses are routed from.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d     = cnt_q;
    cur_tgt_d = cur_tgt_q;
    if (addr_hs) cur_tgt_d = tgt_i;
    unique case ({addr_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State register with synchronous reset; in-flight state is discarded on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      cnt_q     <= '0;
      cur_tgt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cur_tgt_q <= cur_tgt_d;
    end
  end

  // Registered response routing: one-hot of the current target while anything is in flight.
  always_comb begin
    for (int i = 0; i < SLAVE_NUM; i++) rsp_sel_o[i] = cnt_nz & (cur_tgt_q == TW'(i));
    rsp_decerr_o = cnt_nz & (cur_tgt_q == ERR_TGT);
  end
endmodule

module axi4_lite_addr_decoder #(
  parameter int SLAVE_NUM       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_BASE_ADDR =
    {32'h1000_0000, 32'h0000_1000, 32'h0000_0100, 32'h0000_0000},
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0] SLAVE_ADDR_MASK =
    {32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFFFF_FF00},
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic                  aw_valid,
  input  logic                  aw_ready,
  output logic                  aw_stall,
  output logic [SLAVE_NUM-1:0]  aw_sel,
  output logic                  aw_decerr,
  input  logic                  b_valid,
  input  logic                  b_ready,
  output logic [SLAVE_NUM-1:0]  b_sel,
  output logic                  b_decerr,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic                  ar_valid,
  input  logic                  ar_ready,
  output logic                  ar_stall,
  output logic [SLAVE_NUM-1:0]  ar_sel,
  output logic                  ar_decerr,
  input  logic                  r_valid,
  input  logic                  r_ready,
  output logic [SLAVE_NUM-1:0]  r_sel,
  output logic                  r_decerr
`ifdef AXI_ADDR_DEC_ERR_LOG_EN
  ,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_is_read
`endif
);
  localparam int            TW      = $clog2(SLAVE_NUM + 1);
  localparam logic [TW-1:0] ERR_TGT = TW'(SLAVE_NUM);

  // Window match; scanning downwards lets the lowest matching index win.
  function automatic logic [TW-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] base, mask;
    logic [TW-1:0]         tgt;
    tgt = ERR_TGT;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      base = SLAVE_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      mask = SLAVE_ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      if ((addr & mask) == (base & mask)) tgt = TW'(i);
    end
    return tgt;
  endfunction

  logic [TW-1:0] aw_tgt, ar_tgt;
  assign aw_tgt = decode(aw_addr);
  assign ar_tgt = decode(ar_addr);

  // Zero-latency address select and DECERR flag, qualified by VALID.
  always_comb begin
    for (int i = 0; i < SLAVE_NUM; i++) begin
      aw_sel[i] = aw_valid & (aw_tgt == TW'(i));
      ar_sel[i] = ar_valid & (ar_tgt == TW'(i));
    end
    aw_decerr = aw_valid & (aw_tgt == ERR_TGT);
    ar_decerr = ar_valid & (ar_tgt == ERR_TGT);
  end

  axi4_lite_addr_decoder_chan #(
    .SLAVE_NUM(SLAVE_NUM), .MAX_OUTSTANDING(MAX_OUTSTANDING), .TW(TW)
  ) u_wr (
    .clk(clk), .rst(rst), .tgt_i(aw_tgt), .valid_i(aw_valid), .ready_i(aw_ready),
    .rsp_valid_i(b_valid), .rsp_ready_i(b_ready),
    .stall_o(aw_stall), .rsp_sel_o(b_sel), .rsp_decerr_o(b_decerr)
  );

  axi4_lite_addr_decoder_chan #(
    .SLAVE_NUM(SLAVE_NUM), .MAX_OUTSTANDING(MAX_OUTSTANDING), .TW(TW)
  ) u_rd (
    .clk(clk), .rst(rst), .tgt_i(ar_tgt), .valid_i(ar_valid), .ready_i(ar_ready),
    .rsp_valid_i(r_valid), .rsp_ready_i(r_ready),
    .stall_o(ar_stall), .rsp_sel_o(r_sel), .rsp_decerr_o(r_decerr)
  );

`ifdef AXI_ADDR_DEC_ERR_LOG_EN
  logic                  aw_err_hs, ar_err_hs;
  logic                  err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  err_is_read_q, err_is_read_d;

  assign aw_err_hs = aw_valid & aw_ready & ~aw_stall & aw_decerr;
  assign ar_err_hs = ar_valid & ar_ready & ~ar_stall & ar_decerr;

  // Error log next-state: write capture beats read capture, any capture beats clear.
  always_comb begin
    err_valid_d   = err_valid_q;
    err_addr_d    = err_addr_q;
    err_is_read_d = err_is_read_q;
    if (aw_err_hs) begin
      err_valid_d   = 1'b1;
      err_addr_d    = aw_addr;
      err_is_read_d = 1'b0;
    end else if (ar_err_hs) begin
      err_valid_d   = 1'b1;
      err_addr_d    = ar_addr;
      err_is_read_d = 1'b1;
    end else if (err_clr) begin
      err_valid_d   = 1'b0;
    end
  end

  // Error log registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_q   <= 1'b0;
      err_addr_q    <= '0;
      err_is_read_q <= 1'b0;
    end else begin
      err_valid_q   <= err_valid_d;
      err_addr_q    <= err_addr_d;
      err_is_read_q <= err_is_read_d;
    end
  end

  assign err_valid   = err_valid_q;
  assign err_addr    = err_addr_q;
  assign err_is_read = err_is_read_q;
`endif
endmodule

// File: tb/tb_axi4_lite_addr_decoder.sv
// Self-checking bench for axi4_lite_addr_decoder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based transaction model.
module tb_axi4_lite_addr_decoder;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] aw_addr = '0, ar_addr = '0;
  logic        aw_valid = 0, aw_ready = 0, b_valid = 0, b_ready = 0;
  logic        ar_valid = 0, ar_ready = 0, r_valid = 0, r_ready = 0;
  logic        aw_stall, aw_decerr, b_decerr, ar_stall, ar_decerr, r_decerr;
  logic [3:0]  aw_sel, b_sel, ar_sel, r_sel;
`ifdef AXI_ADDR_DEC_ERR_LOG_EN
  logic        err_clr = 0, err_valid, err_is_read;
  logic [31:0] err_addr;
`endif

  axi4_lite_addr_decoder dut (
    .clk(clk), .rst(rst),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_stall(aw_stall),
    .aw_sel(aw_sel), .aw_decerr(aw_decerr), .b_valid(b_valid), .b_ready(b_ready),
    .b_sel(b_sel), .b_decerr(b_decerr),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_stall(ar_stall),
    .ar_sel(ar_sel), .ar_decerr(ar_decerr), .r_valid(r_valid), .r_ready(r_ready),
    .r_sel(r_sel), .r_decerr(r_decerr)
`ifdef AXI_ADDR_DEC_ERR_LOG_EN
    , .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr), .err_is_read(err_is_read)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] base[4] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_1000, 32'h1000_0000};
  logic [31:0] mask[4] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFF0};

  // Slave index of the first matching window, -1 for unmapped.
  function automatic int target(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & mask[i]) == (base[i] & mask[i])) return i;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int t);
    logic [3:0] e;
    e = '0;
    if (t >= 0) e[t] = 1'b1;
    return e;
  endfunction

  // Each direction keeps the targets of its in-flight transactions in order.
  int wq[$];
  int rq[$];
`ifdef AXI_ADDR_DEC_ERR_LOG_EN
  logic        m_err_valid = 0, m_err_is_read = 0;
  logic [31:0] m_err_addr = '0;
`endif

  function automatic logic m_stall(input logic v, input int t, input int sz, input int last);
    return v && (sz == MAXO || (sz != 0 && t != last));
  endfunction

  always @(posedge clk) begin : model_update
    int  wt, rt, wl, rl;
    logic ws, rs, wacc, racc;
    if (rst) begin
      wq.delete();
      rq.delete();
`ifdef AXI_ADDR_DEC_ERR_LOG_EN
      m_err_valid = 0; m_err_is_read = 0; m_err_addr = '0;
`endif
    end else begin
      wt = target(aw_addr);
      rt = target(ar_addr);
      wl = (wq.size() != 0) ? wq[wq.size()-1] : 0;
      rl = (rq.size() != 0) ? rq[rq.size()-1] : 0;
      ws = m_stall(aw_valid, wt, wq.size(), wl);
      rs = m_stall(ar_valid, rt, rq.size(), rl);
      wacc = aw_valid && aw_ready && !ws;
      racc = ar_valid && ar_ready && !rs;
      if (b_valid && b_ready && wq.size() != 0) void'(wq.pop_front());
      if (r_valid && r_ready && rq.size() != 0) void'(rq.pop_front());
      if (wacc) wq.push_back(wt);
      if (racc) rq.push_back(rt);
`ifdef AXI_ADDR_DEC_ERR_LOG_EN
      if (wacc && wt < 0) begin
        m_err_valid = 1; m_err_addr = aw_addr; m_err_is_read = 0;
      end else if (racc && rt < 0) begin
        m_err_valid = 1; m_err_addr = ar_addr; m_err_is_read = 1;
      end else if (err_clr) m_err_valid = 0;
`endif
    end
  end

  // Compare all outputs against the model every cycle outside reset.
  always @(negedge clk) begin : compare
    int wt, rt, wl, rl;
    if (!rst) begin
      wt = target(aw_addr);
      rt = target(ar_addr);
      wl = (wq.size() != 0) ? wq[wq.size()-1] : 0;
      rl = (rq.size() != 0) ? rq[rq.size()-1] : 0;
      check("m_aw_sel",    aw_sel,    aw_valid ? onehot(wt) : 4'b0);
      check("m_aw_decerr", aw_decerr, aw_valid && wt < 0);
      check("m_aw_stall",  aw_stall,  m_stall(aw_valid, wt, wq.size(), wl));
      check("m_b_sel",     b_sel,     wq.size() != 0 ? onehot(wl) : 4'b0);
      check("m_b_decerr",  b_decerr,  wq.size() != 0 && wl < 0);
      check("m_ar_sel",    ar_sel,    ar_valid ? onehot(rt) : 4'b0);
      check("m_ar_decerr", ar_decerr, ar_valid && rt < 0);
      check("m_ar_stall",  ar_stall,  m_stall(ar_valid, rt, rq.size(), rl));
      check("m_r_sel",     r_sel,     rq.size() != 0 ? onehot(rl) : 4'b0);
      check("m_r_decerr",  r_decerr,  rq.size() != 0 && rl < 0);
`ifdef AXI_ADDR_DEC_ERR_LOG_EN
      check("m_err_valid",   err_valid,   m_err_valid);
      check("m_err_addr",    err_addr,    m_err_addr);
      check("m_err_is_read", err_is_read, m_err_is_read);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr(input logic [31:0] prev);
    if ($urandom_range(0, 1) == 0) return prev;
    case ($urandom_range(0, 7))
      0:       return {24'h0, 8'($urandom)};
      1:       return 32'h0000_0100 | 32'($urandom_range(0, 255));
      2:       return 32'h0000_1000;
      3:       return 32'h1000_0000 | 32'($urandom_range(0, 15));
      4:       return 32'h0000_1004;
      5:       return 32'h2000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] dec_a[4] = '{32'h0000_0010, 32'h0000_0104, 32'h0000_1000, 32'h1000_000C};
  logic [3:0]  dec_s[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    repeat (2) cyc();
    rst = 0;

    // Reset state
    @(negedge clk);
    check("rst_aw_stall", aw_stall, 0);
    check("rst_b_sel",    b_sel,    0);
    check("rst_b_decerr", b_decerr, 0);
    check("rst_ar_stall", ar_stall, 0);
    check("rst_r_sel",    r_sel,    0);
    check("rst_r_decerr", r_decerr, 0);

    // Decode windows
    for (int i = 0; i < 4; i++) begin
      cyc();
      aw_addr = dec_a[i]; aw_valid = 1; aw_ready = 0;
      @(negedge clk);
      check("dec_sel", aw_sel, dec_s[i]);
      check("dec_err", aw_decerr, 0);
    end

    // Unmapped read
    cyc();
    aw_valid = 0;
    ar_addr = 32'h0000_1004; ar_valid = 1; ar_ready = 1;
    @(negedge clk);
    check("unm_ar_sel", ar_sel, 0);
    check("unm_ar_decerr", ar_decerr, 1);
    cyc();
    ar_valid = 0; ar_ready = 0;
    @(negedge clk);
    check("unm_r_decerr", r_decerr, 1);
    check("unm_r_sel", r_sel, 0);
    cyc();
    r_valid = 1; r_ready = 1;
    @(negedge clk);
    check("unm_r_decerr_hold", r_decerr, 1);
    cyc();
    r_valid = 0; r_ready = 0;
    @(negedge clk);
    check("unm_r_decerr_done", r_decerr, 0);

    // Ordering stall
    cyc();
    aw_addr = 32'h0000_0104; aw_valid = 1; aw_ready = 1;
    @(negedge clk);
    check("ord_first_stall", aw_stall, 0);
    cyc();
    aw_addr = 32'h0000_1000;
    @(negedge clk);
    check("ord_stall", aw_stall, 1);
    check("ord_b_sel", b_sel, 4'b0010);
    cyc();
    b_valid = 1; b_ready = 1;
    @(negedge clk);
    check("ord_stall_b", aw_stall, 1);
    cyc();
    b_valid = 0; b_ready = 0;
    @(negedge clk);
    check("ord_unstall", aw_stall, 0);
    cyc();
    aw_valid = 0; aw_ready = 0;
    @(negedge clk);
    check("ord_b_sel2", b_sel, 4'b0100);
    cyc();
    b_valid = 1; b_ready = 1;
    cyc();
    b_valid = 0; b_ready = 0;

    // Depth limit and simultaneous handshakes
    aw_addr = 32'h0000_0010; aw_valid = 1; aw_ready = 1;
    repeat (3) cyc();
    b_valid = 1; b_ready = 1;
    @(negedge clk);
    check("dep_cnt3_stall", aw_stall, 0);
    cyc();
    b_valid = 0; b_ready = 0;
    @(negedge clk);
    check("dep_after_both", aw_stall, 0);
    cyc();
    aw_ready = 0;
    @(negedge clk);
    check("dep_full_stall", aw_stall, 1);
    check("dep_b_sel", b_sel, 4'b0001);
    cyc();
    aw_valid = 0; b_valid = 1; b_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dep_drain_b_sel", b_sel, 4'b0001);
      cyc();
    end
    b_valid = 0; b_ready = 0;
    @(negedge clk);
    check("dep_empty_b_sel", b_sel, 0);

    // Reset mid-operation
    cyc();
    ar_addr = 32'h0000_0010; ar_valid = 1; ar_ready = 1;
    repeat (3) cyc();
    ar_valid = 0; rst = 1;
    cyc();
    rst = 0;
    ar_addr = 32'h1000_0000; ar_valid = 1; ar_ready = 1;
    @(negedge clk);
    check("rmo_r_sel", r_sel, 0);
    check("rmo_ar_stall", ar_stall, 0);
    cyc();
    ar_valid = 0; ar_ready = 0;
    @(negedge clk);
    check("rmo_r_sel_new", r_sel, 4'b1000);
    cyc();
    r_valid = 1; r_ready = 1;
    cyc();
    r_valid = 0; r_ready = 0;

`ifdef AXI_ADDR_DEC_ERR_LOG_EN
    // Error log capture and clear
    aw_addr = 32'h2000_0000; aw_valid = 1; aw_ready = 1;
    cyc();
    aw_valid = 0; aw_ready = 0;
    @(negedge clk);
    check("log_valid", err_valid, 1);
    check("log_addr", err_addr, 32'h2000_0000);
    check("log_is_read", err_is_read, 0);
    cyc();
    b_valid = 1; b_ready = 1; err_clr = 1;
    cyc();
    b_valid = 0; b_ready = 0; err_clr = 0;
    @(negedge clk);
    check("log_clr", err_valid, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst      = ($urandom_range(0, 299) == 0);
      aw_addr  = pick_addr(aw_addr);
      ar_addr  = pick_addr(ar_addr);
      aw_valid = ($urandom_range(0, 3) != 0);
      aw_ready = ($urandom_range(0, 1) != 0);
      ar_valid = ($urandom_range(0, 3) != 0);
      ar_ready = ($urandom_range(0, 1) != 0);
      b_valid  = ($urandom_range(0, 2) == 0);
      b_ready  = ($urandom_range(0, 3) != 0);
      r_valid  = ($urandom_range(0, 2) == 0);
      r_ready  = ($urandom_range(0, 3) != 0);
`ifdef AXI_ADDR_DEC_ERR_LOG_EN
      err_clr  = ($urandom_range(0, 7) == 0);
`endif
    end

    cyc();
    rst = 0;
    aw_valid = 0; ar_valid = 0; b_valid = 0; r_valid = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
